draw_sched: RTL and testbench

DRAW_SCHED -- requirements
Module: draw_sched

---
 rtl/hangman_pkg.sv | 35 +++
 rtl/draw_sched_if.sv | 33 +++
 rtl/prio_arb.sv | 23 ++
 rtl/draw_sched.sv | 178 +++++++++++++++++
 tb/tb_draw_sched.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hangman_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hangman_pkg: screen geometry, palette, requester indices and FSM states.
// Rev 1.0
// ----------------------------------------------------------------------------
package hangman_pkg;

    localparam int SCREEN_W_DEFAULT = 160;
    localparam int SCREEN_H_DEFAULT = 120;

    localparam logic [2:0] WHITE = 3'b111;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLACK = 3'b000;

    // Lower index wins arbitration, so the screen clear always goes first.
    localparam int REQ_CLEAR   = 0;
    localparam int REQ_GALLOWS = 1;
    localparam int REQ_BODY    = 2;
    localparam int REQ_LETTER  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic on_screen(input logic [8:0] px, input logic [7:0] py,
                                       input logic [8:0] lim_x, input logic [7:0] lim_y);
        return (px < lim_x) && (py < lim_y);
    endfunction

endpackage
`default_nettype wire

// File: rtl/draw_sched_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// draw_sched_if: requester bundle plus VGA pixel port of the draw scheduler.
// Rev 1.0
// ----------------------------------------------------------------------------
interface draw_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_x;
    logic [7*NREQ-1:0] req_y;
    logic [8*NREQ-1:0] req_w;
    logic [7*NREQ-1:0] req_h;
    logic [3*NREQ-1:0] req_color;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [7:0]        x;
    logic [6:0]        y;
    logic [2:0]        colour;
    logic              plot;
    logic              busy;

    modport master (
        output req, req_x, req_y, req_w, req_h, req_color,
        input  grant, done, x, y, colour, plot, busy
    );

    modport slave (
        input  req, req_x, req_y, req_w, req_h, req_color,
        output grant, done, x, y, colour, plot, busy
    );
endinterface
`default_nettype wire

// File: rtl/prio_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// prio_arb: combinational fixed-priority one-hot arbiter, bit 0 highest.
// Rev 1.0
// ----------------------------------------------------------------------------
module prio_arb #(
    parameter int NREQ = 4
) (
    input  wire logic [NREQ-1:0] i_req,
    output logic      [NREQ-1:0] o_grant
);
    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_grant = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/draw_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// draw_sched: shares one VGA pixel port among rectangle-fill requesters.
// Rev 1.0
// ----------------------------------------------------------------------------
module draw_sched
    import hangman_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int SCREEN_W = SCREEN_W_DEFAULT,
    parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
    input  wire logic   clk,
    input  wire logic   resetn,
    draw_sched_if.slave bus
);
    localparam logic [8:0] c_LIMIT_X = 9'(SCREEN_W);
    localparam logic [7:0] c_LIMIT_Y = 8'(SCREEN_H);

    state_t          r_state, w_state_next;
    logic [NREQ-1:0] w_sel;
    logic [NREQ-1:0] r_grant, w_grant_next;
    logic [NREQ-1:0] r_done, w_done_next;

    logic [7:0] w_sel_x, w_sel_w;
    logic [6:0] w_sel_y, w_sel_h;
    logic [2:0] w_sel_col;

    logic [7:0] r_x0, w_x0_next, r_w, w_w_next, r_cx, w_cx_next, r_x, w_x_next;
    logic [6:0] r_y0, w_y0_next, r_h, w_h_next, r_cy, w_cy_next, r_y, w_y_next;
    logic [2:0] r_col, w_col_next, r_colour, w_colour_next;
    logic       r_plot, w_plot_next;
    logic [8:0] w_px;
    logic [7:0] w_py;
    logic       w_row_end, w_last;

    prio_arb #(.NREQ(NREQ)) u_arb (
        .i_req   (bus.req),
        .o_grant (w_sel)
    );

    always_comb begin
        w_sel_x   = '0;
        w_sel_y   = '0;
        w_sel_w   = '0;
        w_sel_h   = '0;
        w_sel_col = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel[i]) begin
                w_sel_x   = bus.req_x[8*i +: 8];
                w_sel_y   = bus.req_y[7*i +: 7];
                w_sel_w   = bus.req_w[8*i +: 8];
                w_sel_h   = bus.req_h[7*i +: 7];
                w_sel_col = bus.req_color[3*i +: 3];
            end
        end
    end

    // Output registers are loaded with the pixel the counters are about to
    // hold, so the port shows (x0, y0) the cycle after the request is taken.
    always_comb begin
        w_state_next  = r_state;
        w_grant_next  = r_grant;
        w_done_next   = '0;
        w_x0_next     = r_x0;
        w_y0_next     = r_y0;
        w_w_next      = r_w;
        w_h_next      = r_h;
        w_col_next    = r_col;
        w_cx_next     = r_cx;
        w_cy_next     = r_cy;
        w_x_next      = r_x;
        w_y_next      = r_y;
        w_colour_next = r_colour;
        w_plot_next   = 1'b0;
        w_px          = '0;
        w_py          = '0;
        w_row_end     = (r_cx == r_w - 8'd1);
        w_last        = w_row_end && (r_cy == r_h - 7'd1);

        case (r_state)
            IDLE: begin
                if (|bus.req) begin
                    w_grant_next = w_sel;
                    w_x0_next    = w_sel_x;
                    w_y0_next    = w_sel_y;
                    w_w_next     = w_sel_w;
                    w_h_next     = w_sel_h;
                    w_col_next   = w_sel_col;
                    w_cx_next    = '0;
                    w_cy_next    = '0;
                    if (w_sel_w == 8'd0 || w_sel_h == 7'd0) begin
                        w_state_next = DONE;
                        w_done_next  = w_sel;
                    end else begin
                        w_state_next  = DRAW;
                        w_px          = {1'b0, w_sel_x};
                        w_py          = {1'b0, w_sel_y};
                        w_x_next      = w_sel_x;
                        w_y_next      = w_sel_y;
                        w_colour_next = w_sel_col;
                        w_plot_next   = on_screen(w_px, w_py, c_LIMIT_X, c_LIMIT_Y);
                    end
                end
            end
            DRAW: begin
                if (w_last) begin
                    w_state_next = DONE;
                    w_done_next  = r_grant;
                end else begin
                    if (w_row_end) begin
                        w_cx_next = '0;
                        w_cy_next = r_cy + 7'd1;
                    end else begin
                        w_cx_next = r_cx + 8'd1;
                    end
                    w_px        = {1'b0, r_x0} + {1'b0, w_cx_next};
                    w_py        = {1'b0, r_y0} + {1'b0, w_cy_next};
                    w_x_next    = w_px[7:0];
                    w_y_next    = w_py[6:0];
                    w_plot_next = on_screen(w_px, w_py, c_LIMIT_X, c_LIMIT_Y);
                end
            end
            DONE: begin
                w_state_next = IDLE;
                w_grant_next = '0;
            end
            default: begin
                w_state_next = IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_done   <= '0;
            r_x0     <= '0;
            r_y0     <= '0;
            r_w      <= '0;
            r_h      <= '0;
            r_col    <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_grant  <= w_grant_next;
            r_done   <= w_done_next;
            r_x0     <= w_x0_next;
            r_y0     <= w_y0_next;
            r_w      <= w_w_next;
            r_h      <= w_h_next;
            r_col    <= w_col_next;
            r_cx     <= w_cx_next;
            r_cy     <= w_cy_next;
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_colour <= w_colour_next;
            r_plot   <= w_plot_next;
        end
    end

    assign bus.grant  = r_grant;
    assign bus.done   = r_done;
    assign bus.x      = r_x;
    assign bus.y      = r_y;
    assign bus.colour = r_colour;
    assign bus.plot   = r_plot;
    assign bus.busy   = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_draw_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_draw_sched: directed self-checking bench for the draw scheduler.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_draw_sched;
    import hangman_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    draw_sched_if #(.NREQ(4)) bus ();

    draw_sched #(
        .NREQ     (4),
        .SCREEN_W (160),
        .SCREEN_H (120)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic set_rect(input int i, input int rx, input int ry, input int rw,
                            input int rh, input logic [2:0] col);
        bus.req_x[8*i +: 8]     = 8'(rx);
        bus.req_y[7*i +: 7]     = 7'(ry);
        bus.req_w[8*i +: 8]     = 8'(rw);
        bus.req_h[7*i +: 7]     = 7'(rh);
        bus.req_color[3*i +: 3] = col;
    endtask

    task automatic test_reset();
        bus.req = '0;
        for (int i = 0; i < 4; i++) set_rect(i, 0, 0, 0, 0, BLACK);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.grant, bus.done, bus.plot, bus.busy} !== 10'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got g=%b d=%b p=%b b=%b, want all 0",
                     bus.grant, bus.done, bus.plot, bus.busy);
        end
        total++;
        if ({bus.x, bus.y, bus.colour} !== 18'b0) begin
            bad++;
            $display("FAIL reset_pix: got x=%0d y=%0d c=%b, want 0 0 000", bus.x, bus.y, bus.colour);
        end
        resetn = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.plot} !== 2'b00) begin
            bad++;
            $display("FAIL idle_no_req: got busy=%b plot=%b, want 0 0", bus.busy, bus.plot);
        end
    endtask

    task automatic test_single();
        int ex [6] = '{10, 11, 12, 10, 11, 12};
        int ey [6] = '{20, 20, 20, 21, 21, 21};
        set_rect(REQ_CLEAR, 10, 20, 3, 2, WHITE);
        bus.req = 4'b0001;
        @(negedge clk);
        bus.req = 4'b0000;  // drop mid-job; the job must still complete
        for (int k = 0; k < 6; k++) begin
            total++;
            if ({bus.plot, bus.x, bus.y, bus.colour, bus.grant} !==
                {1'b1, 8'(ex[k]), 7'(ey[k]), WHITE, 4'b0001}) begin
                bad++;
                $display("FAIL single_pix%0d: got p=%b x=%0d y=%0d c=%b g=%b, want p=1 x=%0d y=%0d c=111 g=0001",
                         k, bus.plot, bus.x, bus.y, bus.colour, bus.grant, ex[k], ey[k]);
            end
            @(negedge clk);
        end
        total++;
        if ({bus.grant, bus.done, bus.plot, bus.busy} !== 10'b0001_0001_0_1) begin
            bad++;
            $display("FAIL single_done: got g=%b d=%b p=%b b=%b, want 0001 0001 0 1",
                     bus.grant, bus.done, bus.plot, bus.busy);
        end
        @(negedge clk);
        total++;
        if ({bus.grant, bus.done, bus.plot, bus.busy} !== 10'b0) begin
            bad++;
            $display("FAIL single_idle: got g=%b d=%b p=%b b=%b, want all 0",
                     bus.grant, bus.done, bus.plot, bus.busy);
        end
    endtask

    task automatic test_priority();
        logic [9:0] ctrl [8] = '{10'b0010_0000_1_1, 10'b0010_0000_1_1, 10'b0010_0010_0_1,
                                 10'b0000_0000_0_0, 10'b1000_0000_1_1, 10'b1000_0000_1_1,
                                 10'b1000_1000_0_1, 10'b0000_0000_0_0};
        int         ex   [8] = '{30, 31, 31, 31, 50, 50, 50, 50};
        int         ey   [8] = '{40, 40, 40, 40, 60, 61, 61, 61};
        logic [2:0] ec   [8] = '{RED, RED, RED, RED, GREEN, GREEN, GREEN, GREEN};
        set_rect(REQ_GALLOWS, 30, 40, 2, 1, RED);
        set_rect(REQ_LETTER, 50, 60, 1, 2, GREEN);
        bus.req = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if ({bus.grant, bus.done, bus.plot, bus.busy, bus.x, bus.y, bus.colour} !==
                {ctrl[k], 8'(ex[k]), 7'(ey[k]), ec[k]}) begin
                bad++;
                $display("FAIL prio_cyc%0d: got g=%b d=%b p=%b b=%b x=%0d y=%0d c=%b, want ctrl=%b x=%0d y=%0d c=%b",
                         k, bus.grant, bus.done, bus.plot, bus.busy, bus.x, bus.y, bus.colour,
                         ctrl[k], ex[k], ey[k], ec[k]);
            end
            if (k == 2) bus.req[1] = 1'b0;
            if (k == 6) bus.req[3] = 1'b0;
        end
    endtask

    task automatic test_clip();
        int draw = 0, plots = 0, sx = 0, sy = 0, outside = 0, cyc = 0;
        bit got_done = 0;
        set_rect(REQ_BODY, 158, 118, 4, 4, BLUE);
        bus.req = 4'b0100;
        while (!got_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.done[2]) begin
                got_done = 1;
                bus.req  = '0;
            end else begin
                if (bus.busy) draw++;
                if (bus.plot) begin
                    plots++;
                    sx += int'(bus.x);
                    sy += int'(bus.y);
                    if (int'(bus.x) > 159 || int'(bus.y) > 119) outside++;
                end
            end
        end
        total++;
        if (!got_done) begin
            bad++;
            $display("FAIL clip_done: no done within 40 cycles, want done[2]");
        end
        total++;
        if (draw != 16) begin
            bad++;
            $display("FAIL clip_cycles: got %0d draw cycles, want 16", draw);
        end
        total++;
        if (plots != 4 || sx != 634 || sy != 474 || outside != 0) begin
            bad++;
            $display("FAIL clip_plots: got n=%0d sx=%0d sy=%0d outside=%0d, want 4 634 474 0",
                     plots, sx, sy, outside);
        end
        @(negedge clk);
    endtask

    task automatic test_zero();
        set_rect(REQ_LETTER, 20, 30, 0, 5, WHITE);
        bus.req = 4'b1000;
        @(negedge clk);
        total++;
        if ({bus.grant, bus.done, bus.plot, bus.busy} !== 10'b1000_1000_0_1) begin
            bad++;
            $display("FAIL zero_done: got g=%b d=%b p=%b b=%b, want 1000 1000 0 1",
                     bus.grant, bus.done, bus.plot, bus.busy);
        end
        total++;
        if ({bus.x, bus.y, bus.colour} !== {8'd161, 7'd121, BLUE}) begin
            bad++;
            $display("FAIL zero_hold: got x=%0d y=%0d c=%b, want 161 121 001", bus.x, bus.y, bus.colour);
        end
        bus.req = '0;
        @(negedge clk);
        total++;
        if ({bus.grant, bus.done, bus.busy} !== 9'b0) begin
            bad++;
            $display("FAIL zero_idle: got g=%b d=%b b=%b, want all 0", bus.grant, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        int  cyc   = 0;
        bit  seen  = 0;
        set_rect(REQ_GALLOWS, 5, 6, 5, 5, WHITE);
        bus.req = 4'b0010;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.plot, bus.x, bus.y} !== {1'b1, 8'd7, 7'd6}) begin
            bad++;
            $display("FAIL rmid_pix3: got p=%b x=%0d y=%0d, want 1 7 6", bus.plot, bus.x, bus.y);
        end
        resetn = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.grant, bus.done, bus.plot, bus.busy, bus.x, bus.y, bus.colour} !== 28'b0) begin
            bad++;
            $display("FAIL rmid_abort: got g=%b d=%b p=%b b=%b x=%0d y=%0d c=%b, want all 0",
                     bus.grant, bus.done, bus.plot, bus.busy, bus.x, bus.y, bus.colour);
        end
        resetn = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.plot, bus.x, bus.y, bus.grant} !== {1'b1, 8'd5, 7'd6, 4'b0010}) begin
            bad++;
            $display("FAIL rmid_restart: got p=%b x=%0d y=%0d g=%b, want 1 5 6 0010",
                     bus.plot, bus.x, bus.y, bus.grant);
        end
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.done[1]) begin
                seen    = 1;
                bus.req = '0;
            end
        end
        total++;
        if (!seen || cyc != 25) begin
            bad++;
            $display("FAIL rmid_len: got done=%0d after %0d cycles, want done after 25", seen, cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [9:0] ctrl [6] = '{10'b0001_0000_1_1, 10'b0001_0001_0_1, 10'b0000_0000_0_0,
                                 10'b0001_0000_1_1, 10'b0001_0001_0_1, 10'b0000_0000_0_0};
        set_rect(REQ_CLEAR, 1, 1, 1, 1, GREEN);
        bus.req = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if ({bus.grant, bus.done, bus.plot, bus.busy} !== ctrl[k]) begin
                bad++;
                $display("FAIL b2b_cyc%0d: got g=%b d=%b p=%b b=%b, want %b",
                         k, bus.grant, bus.done, bus.plot, bus.busy, ctrl[k]);
            end
            if (k == 3) bus.req = '0;
        end
    endtask

    task automatic test_full_clear();
        int  plots = 0, busyc = 0, cyc = 0;
        bit  ended = 0;
        set_rect(REQ_CLEAR, 0, 0, 160, 120, BLACK);
        bus.req = 4'b0001;
        @(negedge clk);
        total++;
        if ({bus.plot, bus.x, bus.y, bus.colour} !== {1'b1, 8'd0, 7'd0, BLACK}) begin
            bad++;
            $display("FAIL clear_first: got p=%b x=%0d y=%0d c=%b, want 1 0 0 000",
                     bus.plot, bus.x, bus.y, bus.colour);
        end
        while (!ended && cyc < 20100) begin
            if (bus.busy) busyc++;
            if (bus.plot) plots++;
            if (bus.done[0]) bus.req = '0;
            @(negedge clk);
            cyc++;
            if (!bus.busy) ended = 1;
        end
        total++;
        if (!ended || plots != 19200) begin
            bad++;
            $display("FAIL clear_plots: got %0d plots (ended=%0d), want 19200", plots, ended);
        end
        total++;
        if (busyc != 19201) begin
            bad++;
            $display("FAIL clear_busy: got busy for %0d cycles, want 19201", busyc);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_clip();
        test_zero();
        test_reset_mid();
        test_back_to_back();
        test_full_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
